// File: rtl/game_gfx_pkg.sv
// Shared graphics definitions for the frame compositor.
//   - Screen and sprite-sheet geometry, the transparent colour key.
//   - Blitter FSM state encoding.
//   - Descriptor structs: source rectangle and destination position.
//   - Address helpers for sprite VRAM (16-bit) and the framebuffer (15-bit).
package game_gfx_pkg;

    localparam int         VRAM_W      = 160;
    localparam int         FB_W        = 160;
    localparam int         FB_H        = 120;
    localparam logic [7:0] TRANSPARENT = 8'hE3;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RUN,
        DRAIN,
        NEXT,
        DONE
    } blit_state_t;

    typedef struct packed {
        logic [9:0] inicio_X;
        logic [9:0] inicio_Y;
        logic [9:0] final_X;
        logic [9:0] final_Y;
    } rect_t;

    typedef struct packed {
        logic [9:0] X;
        logic [9:0] Y;
    } pos_t;

    // Sprite-sheet address; the result wraps at 16 bits by construction.
    function automatic logic [15:0] vram_addr(input logic [15:0] x, input logic [15:0] y);
        return y * 16'(VRAM_W) + x;
    endfunction

    // Framebuffer address; only meaningful for unclipped coordinates.
    function automatic logic [14:0] fb_addr(input logic [10:0] x, input logic [10:0] y);
        return {4'b0, y} * 15'(FB_W) + {4'b0, x};
    endfunction

endpackage

// File: rtl/blit_pipe.sv
// Delay line that carries the write-side context of each VRAM read until the
// read data returns, so the write lines up with its pixel.
//   clk, reset        : clock, asynchronous active-low reset
//   push_valid/clip/addr : context captured alongside a read
//   tap_valid/clip/addr  : the same context DEPTH cycles later
module blit_pipe import game_gfx_pkg::*; #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_valid,
    input  logic              push_clip,
    input  logic [ADDR_W-1:0] push_addr,
    output logic              tap_valid,
    output logic              tap_clip,
    output logic [ADDR_W-1:0] tap_addr
);

    typedef struct packed {
        logic              valid;
        logic              clip;
        logic [ADDR_W-1:0] addr;
    } stage_t;

    stage_t stages [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= '{valid: push_valid, clip: push_clip, addr: push_addr};
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tap_valid = stages[DEPTH-1].valid;
    assign tap_clip  = stages[DEPTH-1].clip;
    assign tap_addr  = stages[DEPTH-1].addr;

endmodule

// File: rtl/layer_blitter.sv
// Frame compositor: walks layer descriptors 0..NUM_LAYERS-1 once per start,
// copying each source rectangle from sprite VRAM into the framebuffer in
// raster order, skipping the transparent key and clipping at screen edges.
//   clk, reset          : clock, asynchronous active-low reset
//   start               : frame request, sampled in IDLE only
//   busy, done          : frame in progress / one-cycle completion pulse
//   layer               : descriptor index presented to game logic
//   vram_inicio_*/final_*, FB_X/FB_Y : descriptor for the current layer
//   vram_rd_*           : sprite read port, data returns RD_LAT cycles later
//   fb_wr_*             : framebuffer write port
//
// state | meaning
// IDLE  | waiting for start
// SETUP | latch descriptor for the current layer
// RUN   | one VRAM read per cycle over the rectangle
// DRAIN | let the last RD_LAT reads return
// NEXT  | advance layer or finish
// DONE  | done pulse, layer back to 0
module layer_blitter import game_gfx_pkg::*; #(
    parameter int NUM_LAYERS = 14,
    parameter int PIX_W      = 8,
    parameter int RD_LAT     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [32:0]      layer,
    input  logic [9:0]       vram_inicio_X,
    input  logic [9:0]       vram_inicio_Y,
    input  logic [9:0]       vram_final_X,
    input  logic [9:0]       vram_final_Y,
    input  logic [9:0]       FB_X,
    input  logic [9:0]       FB_Y,
    output logic             vram_rd_en,
    output logic [15:0]      vram_rd_addr,
    input  logic [PIX_W-1:0] vram_rd_data,
    output logic             fb_wr_en,
    output logic [14:0]      fb_wr_addr,
    output logic [PIX_W-1:0] fb_wr_data
);

    localparam int DRAIN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    blit_state_t        state;
    blit_state_t        state_nxt;
    rect_t              rect_q;
    pos_t               pos_q;
    logic [9:0]         dx;
    logic [9:0]         dy;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [32:0]        layer_q;

    logic [9:0]         w_m1;
    logic [9:0]         h_m1;
    logic               desc_empty;
    logic               last_px;
    logic               last_layer;
    logic [10:0]        fx;
    logic [10:0]        fy;
    logic               clip;
    logic               tap_valid;
    logic               tap_clip;
    logic [14:0]        tap_addr;

    // The emptiness test looks at the live inputs because the latched copy
    // only becomes valid at the end of SETUP.
    assign desc_empty = (vram_final_X < vram_inicio_X) || (vram_final_Y < vram_inicio_Y);
    assign w_m1       = rect_q.final_X - rect_q.inicio_X;
    assign h_m1       = rect_q.final_Y - rect_q.inicio_Y;
    assign last_px    = (dx == w_m1) && (dy == h_m1);
    assign last_layer = (layer_q == 33'(NUM_LAYERS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = SETUP;
            SETUP: state_nxt = desc_empty ? NEXT : RUN;
            RUN:   if (last_px) state_nxt = DRAIN;
            DRAIN: if (drain_cnt == '0) state_nxt = NEXT;
            NEXT:  state_nxt = last_layer ? DONE : SETUP;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rect_q    <= '0;
            pos_q     <= '0;
            dx        <= '0;
            dy        <= '0;
            drain_cnt <= '0;
            layer_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    layer_q <= '0;
                end
                SETUP: begin
                    rect_q.inicio_X <= vram_inicio_X;
                    rect_q.inicio_Y <= vram_inicio_Y;
                    rect_q.final_X  <= vram_final_X;
                    rect_q.final_Y  <= vram_final_Y;
                    pos_q.X         <= FB_X;
                    pos_q.Y         <= FB_Y;
                    dx              <= '0;
                    dy              <= '0;
                    drain_cnt       <= DRAIN_W'(RD_LAT - 1);
                end
                RUN: begin
                    if (dx == w_m1) begin
                        dx <= '0;
                        dy <= dy + 10'd1;
                    end else begin
                        dx <= dx + 10'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
                end
                NEXT: begin
                    layer_q <= last_layer ? '0 : layer_q + 33'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = state inside {SETUP, RUN, DRAIN, NEXT};
    assign done  = (state == DONE);
    assign layer = layer_q;

    assign vram_rd_en   = (state == RUN);
    assign vram_rd_addr = vram_rd_en
                        ? vram_addr(16'(rect_q.inicio_X) + 16'(dx), 16'(rect_q.inicio_Y) + 16'(dy))
                        : '0;

    // 11-bit destination coordinates cannot wrap for any 10-bit origin/offset.
    assign fx   = 11'(pos_q.X) + 11'(dx);
    assign fy   = 11'(pos_q.Y) + 11'(dy);
    assign clip = (fx >= 11'(FB_W)) || (fy >= 11'(FB_H));

    blit_pipe #(
        .DEPTH  (RD_LAT),
        .ADDR_W (15)
    ) u_pipe (
        .clk        (clk),
        .reset      (reset),
        .push_valid (vram_rd_en),
        .push_clip  (clip),
        .push_addr  (fb_addr(fx, fy)),
        .tap_valid  (tap_valid),
        .tap_clip   (tap_clip),
        .tap_addr   (tap_addr)
    );

    assign fb_wr_en   = tap_valid && !tap_clip && (vram_rd_data != PIX_W'(TRANSPARENT));
    assign fb_wr_addr = fb_wr_en ? tap_addr : '0;
    assign fb_wr_data = fb_wr_en ? vram_rd_data : '0;

endmodule

// File: tb/tb_layer_blitter.sv
module tb_layer_blitter;

    localparam int NL  = 14;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [32:0] layer;
    logic [9:0]  vram_inicio_X, vram_inicio_Y, vram_final_X, vram_final_Y, FB_X, FB_Y;
    logic        vram_rd_en;
    logic [15:0] vram_rd_addr;
    logic [7:0]  vram_rd_data;
    logic        fb_wr_en;
    logic [14:0] fb_wr_addr;
    logic [7:0]  fb_wr_data;

    layer_blitter #(.NUM_LAYERS(NL), .PIX_W(8), .RD_LAT(LAT)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .layer         (layer),
        .vram_inicio_X (vram_inicio_X),
        .vram_inicio_Y (vram_inicio_Y),
        .vram_final_X  (vram_final_X),
        .vram_final_Y  (vram_final_Y),
        .FB_X          (FB_X),
        .FB_Y          (FB_Y),
        .vram_rd_en    (vram_rd_en),
        .vram_rd_addr  (vram_rd_addr),
        .vram_rd_data  (vram_rd_data),
        .fb_wr_en      (fb_wr_en),
        .fb_wr_addr    (fb_wr_addr),
        .fb_wr_data    (fb_wr_data)
    );

    always #5 clk = ~clk;

    typedef struct { int ix; int iy; int fx; int fy; int px; int py; } desc_t;
    typedef struct packed { logic [15:0] src; logic wr; logic [14:0] fa; logic [7:0] d; } px_t;
    typedef struct { int at_cyc; logic [14:0] fa; logic [7:0] d; } wr_t;

    desc_t      desc [NL];
    logic [7:0] vram [65536];
    logic [7:0] fb   [32768];
    logic [7:0] rd_pipe [LAT];
    px_t        pq[$];
    wr_t        wq[$];

    int checks = 0, errors = 0, cyc = 0;
    int done_cnt = 0, nwrites = 0, first_wr_addr = -1, frame_cyc = 0;
    int lyr_reads [16];
    int lyr_stamp [16];
    logic [32:0] prev_layer = '0;
    bit   mon_en = 0;
    px_t  mon_p;
    wr_t  mon_w;
    int   li;

    always_comb begin
        li = int'(layer[3:0]);
        if (li >= NL) li = 0;
        vram_inicio_X = 10'(desc[li].ix);
        vram_inicio_Y = 10'(desc[li].iy);
        vram_final_X  = 10'(desc[li].fx);
        vram_final_Y  = 10'(desc[li].fy);
        FB_X          = 10'(desc[li].px);
        FB_Y          = 10'(desc[li].py);
    end

    // Memory models: VRAM with LAT-cycle read latency, framebuffer write port.
    always @(posedge clk) begin
        rd_pipe[0] <= vram_rd_en ? vram[vram_rd_addr] : 8'h00;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (fb_wr_en) fb[fb_wr_addr] <= fb_wr_data;
        cyc <= cyc + 1;
    end
    assign vram_rd_data = rd_pipe[LAT-1];

    // Scoreboard monitor: each read pops the expected pixel and, when that
    // pixel should land, schedules a write LAT cycles later.
    always @(negedge clk) begin
        if (reset && mon_en) begin
            if (vram_rd_en) begin
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL rd_extra: got read addr=%0d, expected no read", vram_rd_addr);
                end else begin
                    mon_p = pq.pop_front();
                    if (vram_rd_addr !== mon_p.src) begin
                        errors++;
                        $display("FAIL rd_addr: got %0d expected %0d (cyc %0d)", vram_rd_addr, mon_p.src, cyc);
                    end
                    if (mon_p.wr) wq.push_back('{cyc + LAT, mon_p.fa, mon_p.d});
                end
                lyr_reads[layer[3:0]]++;
            end
            if (fb_wr_en) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL wr_extra: got write addr=%0d data=%0h, expected none", fb_wr_addr, fb_wr_data);
                end else begin
                    mon_w = wq.pop_front();
                    if (cyc != mon_w.at_cyc || fb_wr_addr !== mon_w.fa || fb_wr_data !== mon_w.d) begin
                        errors++;
                        $display("FAIL wr: got cyc=%0d addr=%0d data=%0h expected cyc=%0d addr=%0d data=%0h",
                                 cyc, fb_wr_addr, fb_wr_data, mon_w.at_cyc, mon_w.fa, mon_w.d);
                    end
                end
                if (first_wr_addr < 0) first_wr_addr = int'(fb_wr_addr);
                nwrites++;
            end
            if (done) done_cnt++;
            if (layer != prev_layer) lyr_stamp[layer[3:0]] = cyc;
            prev_layer = layer;
        end
    end

    task automatic set_default_desc();
        for (int l = 0; l < NL; l++) desc[l] = '{5, 0, 4, 0, 0, 0};
    endtask

    task automatic build_expect(output int cycles, output int nwr);
        int src, fxx, fyy;
        bit clp, wr;
        logic [7:0] d;
        pq.delete();
        wq.delete();
        cycles = 0;
        nwr = 0;
        for (int l = 0; l < NL; l++) begin
            if (desc[l].fx < desc[l].ix || desc[l].fy < desc[l].iy) begin
                cycles += 2;
            end else begin
                cycles += 1 + (desc[l].fx - desc[l].ix + 1) * (desc[l].fy - desc[l].iy + 1) + LAT + 1;
                for (int y = desc[l].iy; y <= desc[l].fy; y++) begin
                    for (int x = desc[l].ix; x <= desc[l].fx; x++) begin
                        src = y * 160 + x;
                        fxx = desc[l].px + x - desc[l].ix;
                        fyy = desc[l].py + y - desc[l].iy;
                        clp = (fxx >= 160) || (fyy >= 120);
                        d   = vram[src];
                        wr  = !clp && (d != 8'hE3);
                        pq.push_back('{16'(src), wr, 15'(fyy * 160 + fxx), d});
                        if (wr) nwr++;
                    end
                end
            end
        end
    endtask

    // mode 1: rewrite layer-0 descriptor mid-layer; mode 2: extra start pulse mid-frame.
    task automatic run_frame(input string name, input int mode);
        int exp_cyc, exp_wr, a;
        bit got;
        build_expect(exp_cyc, exp_wr);
        nwrites = 0;
        first_wr_addr = -1;
        done_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            lyr_reads[i] = 0;
            lyr_stamp[i] = -1;
        end
        mon_en = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = cyc;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
        end
        got = 0;
        for (int t = 0; t < exp_cyc + 100; t++) begin
            if (done === 1'b1) begin
                got = 1;
                break;
            end
            if (mode == 1 && t == 50) begin
                desc[0].px = 0;
                desc[0].py = 0;
            end
            if (mode == 2 && t == 5) start = 1'b1;
            if (mode == 2 && t == 6) start = 1'b0;
            @(negedge clk);
        end
        frame_cyc = cyc - a;
        checks++;
        if (!got || frame_cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s done_time: got %0d cycles (seen=%0d) expected %0d", name, frame_cyc, got, exp_cyc);
        end
        checks++;
        if (nwrites != exp_wr || pq.size() != 0 || wq.size() != 0) begin
            errors++;
            $display("FAIL %s drain: writes=%0d expected %0d, pending reads=%0d writes=%0d expected 0",
                     name, nwrites, exp_wr, pq.size(), wq.size());
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt != 1 || busy !== 1'b0 || layer !== 33'd0) begin
            errors++;
            $display("FAIL %s post_frame: done_cnt=%0d busy=%b layer=%0d expected 1/0/0", name, done_cnt, busy, layer);
        end
    endtask

    task automatic test_reset();
        set_default_desc();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, layer, vram_rd_en, vram_rd_addr, fb_wr_en, fb_wr_addr, fb_wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b layer=%0d rd_en=%b rd_addr=%0d wr_en=%b wr_addr=%0d wr_data=%0h expected all 0",
                     busy, done, layer, vram_rd_en, vram_rd_addr, fb_wr_en, fb_wr_addr, fb_wr_data);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    task automatic test_full_screen();
        set_default_desc();
        desc[0] = '{0, 0, 159, 119, 0, 0};
        run_frame("full", 0);
        checks++;
        if (nwrites != 19200 || first_wr_addr != 0 || frame_cyc != 19204 + 26) begin
            errors++;
            $display("FAIL full_totals: writes=%0d first=%0d cycles=%0d expected 19200/0/19230", nwrites, first_wr_addr, frame_cyc);
        end
        checks++;
        if (fb[19199] !== vram[19199] || fb[8000] !== vram[8000]) begin
            errors++;
            $display("FAIL full_fb: fb[19199]=%0h fb[8000]=%0h expected %0h/%0h", fb[19199], fb[8000], vram[19199], vram[8000]);
        end
    endtask

    logic [7:0] saved [100];

    task automatic test_transparency();
        int off;
        set_default_desc();
        desc[0] = '{0, 240, 39, 273, 55, 74};
        for (int k = 0; k < 100; k++) begin
            off = k * 13 + 1;
            saved[k] = vram[(240 + off / 40) * 160 + off % 40];
            vram[(240 + off / 40) * 160 + off % 40] = 8'hE3;
        end
        run_frame("transparency", 1);
        checks++;
        if (nwrites != 1260 || first_wr_addr != 11895 || frame_cyc != 1390) begin
            errors++;
            $display("FAIL transp_totals: writes=%0d first=%0d cycles=%0d expected 1260/11895/1390", nwrites, first_wr_addr, frame_cyc);
        end
        for (int k = 0; k < 100; k++) begin
            off = k * 13 + 1;
            vram[(240 + off / 40) * 160 + off % 40] = saved[k];
        end
    endtask

    task automatic test_clipping();
        set_default_desc();
        desc[0] = '{0, 240, 39, 273, 150, 100};
        run_frame("clipping", 0);
        checks++;
        if (nwrites != 200 || first_wr_addr != 100 * 160 + 150 || frame_cyc != 1390) begin
            errors++;
            $display("FAIL clip_totals: writes=%0d first=%0d cycles=%0d expected 200/16150/1390", nwrites, first_wr_addr, frame_cyc);
        end
    endtask

    task automatic test_degenerate();
        set_default_desc();
        desc[0] = '{2, 3, 9, 6, 0, 0};
        desc[2] = '{0, 0, 1, 1, 100, 100};
        run_frame("degenerate", 0);
        checks++;
        if (lyr_reads[0] != 32 || lyr_reads[1] != 0 || lyr_reads[2] != 4) begin
            errors++;
            $display("FAIL degen_reads: l0=%0d l1=%0d l2=%0d expected 32/0/4", lyr_reads[0], lyr_reads[1], lyr_reads[2]);
        end
        checks++;
        if (lyr_stamp[2] - lyr_stamp[1] != 2) begin
            errors++;
            $display("FAIL degen_len: got %0d cycles expected 2", lyr_stamp[2] - lyr_stamp[1]);
        end
    endtask

    task automatic test_overlap();
        set_default_desc();
        desc[0] = '{0, 0, 0, 0, 10, 10};
        desc[1] = '{1, 0, 1, 0, 10, 10};
        vram[0] = 8'h10;
        vram[1] = 8'h20;
        fb[1610] = 8'h00;
        run_frame("overlap", 2);
        checks++;
        if (fb[1610] !== 8'h20 || frame_cyc != 34) begin
            errors++;
            $display("FAIL overlap_final: fb=%0h cycles=%0d expected 20/34", fb[1610], frame_cyc);
        end
    endtask

    task automatic test_reset_midrun();
        int ec, ew;
        bit got;
        set_default_desc();
        for (int l = 0; l < 3; l++) desc[l] = '{0, 0, 3, 3, 0, 0};
        desc[3] = '{20, 0, 29, 9, 20, 20};
        build_expect(ec, ew);
        done_cnt = 0;
        mon_en = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int t = 0; t < 400; t++) begin
            if (layer === 33'd3 && vram_rd_en === 1'b1) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rst_reach_l3: layer=%0d rd_en=%b expected layer 3 reading", layer, vram_rd_en);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (fb_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_write: wr_en=%b expected 1", fb_wr_en);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || fb_wr_en !== 1'b0 || layer !== 33'd0 || vram_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_immediate: busy=%b wr_en=%b layer=%0d rd_en=%b expected 0/0/0/0", busy, fb_wr_en, layer, vram_rd_en);
        end
        mon_en = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0 || done_cnt != 0) begin
            errors++;
            $display("FAIL rst_no_done: done=%b count=%0d expected 0/0", done, done_cnt);
        end
        pq.delete();
        wq.delete();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || layer !== 33'd0) begin
            errors++;
            $display("FAIL rst_idle: busy=%b layer=%0d expected 0/0", busy, layer);
        end
        run_frame("after_reset", 0);
    endtask

    initial begin
        logic [7:0] v;
        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom_range(0, 255));
            if (v == 8'hE3) v = 8'h00;
            vram[i] = v;
        end
        for (int i = 0; i < 32768; i++) fb[i] = 8'h00;
        for (int i = 0; i < LAT; i++) rd_pipe[i] = 8'h00;
        test_reset();
        test_full_screen();
        test_transparency();
        test_clipping();
        test_degenerate();
        test_overlap();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
